mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive ICache rejections after which ICache is granted.
REQ-002 clock  in  1  system clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 Icache_command  in  BUS_COMMAND  ICache controller request (BUS_NONE/BUS_LOAD).
REQ-005 Icache_addr  in  XLEN  ICache request address, 8-byte aligned.
REQ-006 Dcache_command  in  BUS_COMMAND  DCache request (BUS_NONE/BUS_LOAD/BUS_STORE).
REQ-007 Dcache_addr  in  XLEN  DCache request address; Dcache_data  in  64  store data.
REQ-008 mem2arb_response  in  4  memory accept tag, 0 = not accepted; same cycle as command.
REQ-009 mem2arb_tag  in  4  memory completion tag, 0 = none; mem2arb_data  in  64  completion data.
REQ-010 arb2mem_command  out  BUS_COMMAND; arb2mem_addr  out  XLEN; arb2mem_data  out  64  granted request to memory.
REQ-011 arb2I_response  out  4; arb2I_tag  out  4; arb2I_data  out  64  ICache-side memory view.
REQ-012 arb2D_response  out  4; arb2D_tag  out  4; arb2D_data  out  64  DCache-side memory view.
REQ-013 reject_I_req  out  1; reject_D_req  out  1  requester lost arbitration this cycle.
REQ-014 tag_error  out  1  sticky: completion tag arrived with no recorded owner.

Function
REQ-015 Grant is combinational per cycle; at most one requester drives memory.
REQ-016 Default priority: DCache wins whenever Dcache_command != BUS_NONE.
REQ-017 Starvation counter (3+ bits, saturating at STARVE_LIMIT) increments each cycle ICache requests and is rejected; clears when ICache is granted or Icache_command == BUS_NONE.
REQ-018 When counter == STARVE_LIMIT and ICache requests, ICache wins regardless of DCache.
REQ-019 reject_I_req = ICache requesting && not granted; reject_D_req = DCache requesting && not granted.
REQ-020 Granted side: arb2mem_* = its command/addr (data = Dcache_data for DCache, 0 for ICache); no grant: BUS_NONE, addr 0, data 0.
REQ-021 arb2X_response = mem2arb_response for granted side X, 0 for the other side.
REQ-022 Owner table: 15 entries indexed by tags 1..15, each FREE/ICACHE/DCACHE.
REQ-023 On posedge with granted BUS_LOAD and mem2arb_response != 0, entry[response] <= granting side.
REQ-024 Stores never record an owner (no completion expected).
REQ-025 Completion: mem2arb_tag != 0 and entry == ICACHE -> arb2I_tag = tag, arb2I_data = mem2arb_data, arb2D_tag = 0; DCACHE symmetric; entry cleared at next posedge.
REQ-026 Completion to FREE entry: both arb2X_tag = 0, tag_error set (sticky until reset).
REQ-027 Same-cycle accept and completion on same tag: clear then record (new owner wins).
REQ-028 Zero extra latency: all outputs combinational from inputs plus registered table/counter.
REQ-029 Non-owner data outputs driven 0.

Reset
REQ-030 Reset: all owner entries FREE, counter 0, tag_error 0.
REQ-031 In reset cycle arbiter outputs BUS_NONE, all response/tag outputs 0, rejects 0.
REQ-032 Reset mid-transfer discards ownership; late completions then raise tag_error only if they arrive after reset deasserts.

Structure
REQ-033 OWNER enum (FREE, ICACHE, DCACHE) and STARVE_LIMIT default belong in the shared header package; BUS_COMMAND reused from it.
REQ-034 One sub-module natural: mem_tag_owner_table (record/clear/lookup, 15 entries).

Verification
REQ-035 I and D LOAD together, response=3 -> D granted, reject_I_req=1, arb2D_response=3, arb2I_response=0, entry[3]=DCACHE.
REQ-036 I requests while D requests 4 consecutive cycles -> cycle 5 I granted, reject_D_req=1, counter clears.
REQ-037 I LOAD accepted tag 5, later mem2arb_tag=5 data 0xDEADBEEF -> arb2I_tag=5, arb2I_data=0xDEADBEEF, arb2D_tag=0, entry[5] FREE next cycle.
REQ-038 D STORE accepted tag 7, then mem2arb_tag=7 -> tag_error=1, no side receives tag.
REQ-039 Completion tag 2 and new accept tag 2 same cycle -> old owner gets tag, entry[2] = new owner.
REQ-040 Reset asserted with 3 outstanding tags -> all outputs zero/BUS_NONE, table FREE, tag_error 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the ICache/DCache memory arbiter.
//   BUS_COMMAND : bus command encoding used by caches and memory.
//   OWNER       : owner of an outstanding memory tag.
//   STARVE_LIMIT_DEFAULT : ICache rejections tolerated before ICache is forced.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int XLEN                 = 32;
    localparam int NUM_TAGS             = 15;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        ICACHE = 2'd1,
        DCACHE = 2'd2
    } OWNER;

endpackage

// File: rtl/mem_tag_owner_table.sv
// -----------------------------------------------------------------------------
// mem_tag_owner_table
// Remembers which cache owns each outstanding memory tag (1..15).
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   i_rec_en/tag/owner    : record owner of a newly accepted tag
//   i_clr_en/i_clr_tag    : free a tag whose completion was delivered
//   i_lookup_tag          : tag to look up (0 reads as FREE)
//   o_lookup_owner        : current owner of i_lookup_tag
// -----------------------------------------------------------------------------
module mem_tag_owner_table
    import mem_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_rec_en,
    input  logic [3:0] i_rec_tag,
    input  OWNER       i_rec_owner,
    input  logic       i_clr_en,
    input  logic [3:0] i_clr_tag,
    input  logic [3:0] i_lookup_tag,
    output OWNER       o_lookup_owner
);

    OWNER r_entry [1:NUM_TAGS];

    // Record is applied after clear so a tag completing and being reissued in
    // the same cycle ends up owned by the new requester.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_entry <= '{default: FREE};
        end else begin
            if (i_clr_en && (i_clr_tag != 4'd0))
                r_entry[i_clr_tag] <= FREE;
            if (i_rec_en && (i_rec_tag != 4'd0))
                r_entry[i_rec_tag] <= i_rec_owner;
        end
    end

    always_comb begin
        o_lookup_owner = FREE;
        if (i_lookup_tag != 4'd0)
            o_lookup_owner = r_entry[i_lookup_tag];
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between the ICache and DCache controllers.
// DCache has priority unless ICache has been rejected STARVE_LIMIT cycles in
// a row. Completion tags are routed back to whichever cache was accepted with
// that tag; a completion with no known owner sets the sticky tag_error.
// Ports:
//   clock, reset                         : clock, synchronous active-high reset
//   Icache_command/addr                  : ICache request
//   Dcache_command/addr/data             : DCache request
//   mem2arb_response                     : memory accept tag (0 = not accepted)
//   mem2arb_tag/data                     : memory completion (tag 0 = none)
//   arb2mem_command/addr/data            : granted request to memory
//   arb2I_response/tag/data              : ICache view of memory
//   arb2D_response/tag/data              : DCache view of memory
//   reject_I_req, reject_D_req           : requester lost arbitration
//   tag_error                            : sticky unowned-completion flag
// All outputs are combinational from inputs and registered state.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  BUS_COMMAND       Icache_command,
    input  logic [XLEN-1:0]  Icache_addr,
    input  BUS_COMMAND       Dcache_command,
    input  logic [XLEN-1:0]  Dcache_addr,
    input  logic [63:0]      Dcache_data,
    input  logic [3:0]       mem2arb_response,
    input  logic [3:0]       mem2arb_tag,
    input  logic [63:0]      mem2arb_data,
    output BUS_COMMAND       arb2mem_command,
    output logic [XLEN-1:0]  arb2mem_addr,
    output logic [63:0]      arb2mem_data,
    output logic [3:0]       arb2I_response,
    output logic [3:0]       arb2I_tag,
    output logic [63:0]      arb2I_data,
    output logic [3:0]       arb2D_response,
    output logic [3:0]       arb2D_tag,
    output logic [63:0]      arb2D_data,
    output logic             reject_I_req,
    output logic             reject_D_req,
    output logic             tag_error
);

    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_tag_error;

    logic w_i_req;
    logic w_d_req;
    logic w_starved;
    logic w_grant_i;
    logic w_grant_d;
    logic w_rec_en;
    logic w_clr_en;
    OWNER w_rec_owner;
    OWNER w_cpl_owner;

    // Requests are masked during reset so every output idles in that cycle.
    assign w_i_req   = !reset && (Icache_command != BUS_NONE);
    assign w_d_req   = !reset && (Dcache_command != BUS_NONE);
    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    assign w_grant_i = w_i_req && (!w_d_req || w_starved);
    assign w_grant_d = w_d_req && !w_grant_i;

    // Only loads expect a completion, so stores never take a table entry.
    assign w_rec_en    = (mem2arb_response != 4'd0) &&
                         ((w_grant_i && (Icache_command == BUS_LOAD)) ||
                          (w_grant_d && (Dcache_command == BUS_LOAD)));
    assign w_rec_owner = w_grant_i ? ICACHE : DCACHE;
    assign w_clr_en    = !reset && (mem2arb_tag != 4'd0);

    mem_tag_owner_table u_owner_table (
        .clock          (clock),
        .reset          (reset),
        .i_rec_en       (w_rec_en),
        .i_rec_tag      (mem2arb_response),
        .i_rec_owner    (w_rec_owner),
        .i_clr_en       (w_clr_en),
        .i_clr_tag      (mem2arb_tag),
        .i_lookup_tag   (mem2arb_tag),
        .o_lookup_owner (w_cpl_owner)
    );

    // Starvation counter: counts consecutive ICache rejections, saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_i_req && !w_grant_i) begin
            if (!w_starved)
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end else begin
            r_starve_cnt <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_tag_error <= 1'b0;
        else if (w_clr_en && (w_cpl_owner == FREE))
            r_tag_error <= 1'b1;
    end

    // Masked by reset so the flag reads 0 in the reset cycle itself.
    assign tag_error = r_tag_error && !reset;

    always_comb begin
        arb2mem_command = BUS_NONE;
        arb2mem_addr    = '0;
        arb2mem_data    = '0;
        arb2I_response  = 4'd0;
        arb2D_response  = 4'd0;
        if (w_grant_i) begin
            arb2mem_command = Icache_command;
            arb2mem_addr    = Icache_addr;
            arb2I_response  = mem2arb_response;
        end else if (w_grant_d) begin
            arb2mem_command = Dcache_command;
            arb2mem_addr    = Dcache_addr;
            arb2mem_data    = Dcache_data;
            arb2D_response  = mem2arb_response;
        end
    end

    always_comb begin
        arb2I_tag  = 4'd0;
        arb2I_data = '0;
        arb2D_tag  = 4'd0;
        arb2D_data = '0;
        if (w_clr_en) begin
            if (w_cpl_owner == ICACHE) begin
                arb2I_tag  = mem2arb_tag;
                arb2I_data = mem2arb_data;
            end else if (w_cpl_owner == DCACHE) begin
                arb2D_tag  = mem2arb_tag;
                arb2D_data = mem2arb_data;
            end
        end
    end

    assign reject_I_req = w_i_req && !w_grant_i;
    assign reject_D_req = w_d_req && !w_grant_d;

endmodule
